// File: rtl/rv32_fetch.sv
// rv32 fetch stage: owns the PC, keeps at most one instruction-bus request in flight and
// applies static backward-taken/forward-not-taken prediction before handing words to decode.
module rv32_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic [31:0] instr_address_out,
  output logic        instr_read_out,
  input  logic [31:0] instr_read_value_in,
  input  logic        instr_ready_in,
  input  logic        instr_fault_in,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  exception_cause_out,
  output logic        branch_predicted_taken_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);
  localparam logic [6:0] OP_JAL         = 7'b1101111;
  localparam logic [6:0] OP_BRANCH      = 7'b1100011;
  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_FAULT    = 4'd1;

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALT} state_t;
  state_t state, state_nxt;

  logic [31:0] pc, pc_nxt, drain_addr;
  logic        aligned, fetch_done, skid_ld;
  logic signed [31:0] imm_j, imm_b;
  logic [31:0] pred_pc;
  logic        pred_taken;

  logic [31:0] skid_instr, skid_pc;
  logic        skid_fault, skid_pred;

  logic        vld_p0, exc_p0, bpt_p0, ld_p0;
  logic [3:0]  cause_p0;
  logic [31:0] pc_p0, instr_p0;

  logic        vld_p1, exc_p1, bpt_p1;
  logic [3:0]  cause_p1;
  logic [31:0] pc_p1, instr_p1;

  assign aligned    = (pc[1:0] == 2'b00);
  assign fetch_done = (state == FETCH) && aligned && instr_ready_in;

  assign imm_j = {{12{instr_read_value_in[31]}}, instr_read_value_in[19:12],
                  instr_read_value_in[20], instr_read_value_in[30:21], 1'b0};
  assign imm_b = {{20{instr_read_value_in[31]}}, instr_read_value_in[7],
                  instr_read_value_in[30:25], instr_read_value_in[11:8], 1'b0};

  // Faulted words carry no usable opcode, so they always fall through to pc+4.
  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc + 32'd4;
    if (!instr_fault_in) begin
      if (instr_read_value_in[6:0] == OP_JAL) begin
        pred_taken = 1'b1;
        pred_pc    = pc + $unsigned(imm_j);
      end else if (instr_read_value_in[6:0] == OP_BRANCH && instr_read_value_in[31]) begin
        pred_taken = 1'b1;
        pred_pc    = pc + $unsigned(imm_b);
      end
    end
  end

  always_comb begin
    pc_nxt = pc;
    if (redirect_in)     pc_nxt = redirect_pc_in;
    else if (fetch_done) pc_nxt = pred_pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // After any emitted exception the stage parks in HALT until a redirect arrives.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: begin
        if (redirect_in)          state_nxt = (aligned && !instr_ready_in) ? DRAIN : FETCH;
        else if (!aligned)        state_nxt = stall_in ? FETCH : HALT;
        else if (instr_ready_in) begin
          if (stall_in)            state_nxt = HOLD;
          else if (instr_fault_in) state_nxt = HALT;
        end
      end
      HOLD: begin
        if (redirect_in)    state_nxt = FETCH;
        else if (!stall_in) state_nxt = skid_fault ? HALT : FETCH;
      end
      DRAIN:   if (instr_ready_in) state_nxt = FETCH;
      HALT:    if (redirect_in)    state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  // DRAIN keeps presenting the abandoned address: the bus must see a stable request until ready.
  always_comb begin
    instr_read_out    = 1'b0;
    instr_address_out = pc;
    skid_ld           = 1'b0;
    unique case (state)
      FETCH: begin
        instr_read_out = aligned;
        skid_ld        = fetch_done && stall_in && !redirect_in;
      end
      DRAIN: begin
        instr_read_out    = 1'b1;
        instr_address_out = drain_addr;
      end
      default: ;
    endcase
    if (!reset_n) instr_read_out = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (state == FETCH) drain_addr <= pc;
    if (skid_ld) begin
      skid_instr <= instr_read_value_in;
      skid_pc    <= pc;
      skid_fault <= instr_fault_in;
      skid_pred  <= pred_taken;
    end
  end

  // ---- stage p0: select the entry offered to decode this cycle ----
  always_comb begin
    vld_p0   = 1'b0;
    exc_p0   = 1'b0;
    bpt_p0   = 1'b0;
    cause_p0 = CAUSE_MISALIGN;
    pc_p0    = pc;
    instr_p0 = 32'd0;
    ld_p0    = 1'b0;
    if (redirect_in || flush_in) begin
      ld_p0 = 1'b0;
    end else if (state == FETCH && !aligned) begin
      exc_p0 = 1'b1;
      ld_p0  = 1'b1;
    end else if (fetch_done) begin
      vld_p0   = !instr_fault_in;
      exc_p0   = instr_fault_in;
      cause_p0 = instr_fault_in ? CAUSE_FAULT : CAUSE_MISALIGN;
      bpt_p0   = pred_taken;
      instr_p0 = instr_fault_in ? 32'd0 : instr_read_value_in;
      ld_p0    = 1'b1;
    end else if (state == HOLD) begin
      vld_p0   = !skid_fault;
      exc_p0   = skid_fault;
      cause_p0 = skid_fault ? CAUSE_FAULT : CAUSE_MISALIGN;
      bpt_p0   = skid_pred;
      pc_p0    = skid_pc;
      instr_p0 = skid_fault ? 32'd0 : skid_instr;
      ld_p0    = 1'b1;
    end
  end

  // ---- stage p1: output registers toward decode ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      exc_p1   <= 1'b0;
      bpt_p1   <= 1'b0;
      cause_p1 <= 4'd0;
      pc_p1    <= 32'd0;
      instr_p1 <= 32'd0;
    end else if (!stall_in) begin
      vld_p1   <= vld_p0;
      exc_p1   <= exc_p0;
      bpt_p1   <= bpt_p0;
      cause_p1 <= cause_p0;
      if (ld_p0) begin
        pc_p1    <= pc_p0;
        instr_p1 <= instr_p0;
      end
    end
  end

  assign valid_out                  = vld_p1;
  assign exception_out              = exc_p1;
  assign exception_cause_out        = cause_p1;
  assign branch_predicted_taken_out = bpt_p1;
  assign pc_out                     = pc_p1;
  assign instr_out                  = instr_p1;
endmodule

// File: tb/tb_rv32_fetch.sv
// Bench for rv32_fetch: directed scenarios followed by a randomized run against an
// ISA-level program-order walk of a memory image.
module tb_rv32_fetch;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_in, flush_in, redirect_in;
  logic [31:0] redirect_pc_in;
  logic [31:0] instr_address_out;
  logic        instr_read_out;
  logic [31:0] instr_read_value_in;
  logic        instr_ready_in, instr_fault_in;
  logic        valid_out, exception_out, branch_predicted_taken_out;
  logic [3:0]  exception_cause_out;
  logic [31:0] pc_out, instr_out;

  always #5 clk = ~clk;

  rv32_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .stall_in                   (stall_in),
    .flush_in                   (flush_in),
    .redirect_in                (redirect_in),
    .redirect_pc_in             (redirect_pc_in),
    .instr_address_out          (instr_address_out),
    .instr_read_out             (instr_read_out),
    .instr_read_value_in        (instr_read_value_in),
    .instr_ready_in             (instr_ready_in),
    .instr_fault_in             (instr_fault_in),
    .valid_out                  (valid_out),
    .exception_out              (exception_out),
    .exception_cause_out        (exception_cause_out),
    .branch_predicted_taken_out (branch_predicted_taken_out),
    .pc_out                     (pc_out),
    .instr_out                  (instr_out)
  );

  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wait_left = 0;
  int          wait_mode = 0;   // <0: random 0..2 wait states per request
  logic        fault_on = 1'b0;
  logic [31:0] fault_addr = 32'd0;
  logic [31:0] exp_pc = 32'd0;
  int          emitted = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Program-order successor of a word at pc, straight from the ISA immediate definitions.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] w,
                                           output logic taken);
    int imm;
    taken = 1'b0;
    ref_next = pc + 32'd4;
    if (w[6:0] == 7'h6F) begin
      imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
            - (w[31] ? (1 << 20) : 0);
      taken = 1'b1;
      ref_next = pc + $unsigned(imm);
    end else if (w[6:0] == 7'h63 && w[31]) begin
      imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
      taken = 1'b1;
      ref_next = pc + $unsigned(imm);
    end
  endfunction

  function automatic logic [31:0] enc_b(input int off);
    logic [12:0] b;
    b = off[12:0];
    return {b[12], b[10:5], 5'd2, 5'd1, 3'd0, b[4:1], b[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int off);
    logic [20:0] j;
    j = off[20:0];
    return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'h6F};
  endfunction

  task automatic cycle();
    logic        p_stall, p_flush, p_redir, p_read, p_ready, taken;
    logic [31:0] p_addr, p_rpc, o_pc, o_instr, w, nxt;
    logic [6:0]  o_flags;
    instr_ready_in      = instr_read_out && (wait_left == 0);
    instr_read_value_in = mem[instr_address_out[9:2]];
    instr_fault_in      = instr_ready_in && fault_on && (instr_address_out == fault_addr);
    p_stall = stall_in;  p_flush = flush_in;  p_redir = redirect_in;
    p_read  = instr_read_out;  p_ready = instr_ready_in;
    p_addr  = instr_address_out;  p_rpc = redirect_pc_in;
    o_pc = pc_out;  o_instr = instr_out;
    o_flags = {valid_out, exception_out, branch_predicted_taken_out, exception_cause_out};
    @(posedge clk);
    #1;
    if (p_read && p_ready)
      wait_left = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
    else if (p_read && wait_left > 0)
      wait_left--;
    if (p_read && !p_ready) begin
      chk("bus_addr_stable", instr_address_out, p_addr);
      chk1("bus_read_stable", instr_read_out, 1'b1);
    end
    if (p_redir) exp_pc = p_rpc;
    if (p_stall) begin
      chk("stall_hold_pc", pc_out, o_pc);
      chk("stall_hold_instr", instr_out, o_instr);
      chk("stall_hold_flags", 32'({valid_out, exception_out, branch_predicted_taken_out,
                                   exception_cause_out}), 32'(o_flags));
    end else if (p_redir || p_flush) begin
      chk("redirect_bubble", 32'({valid_out, exception_out, branch_predicted_taken_out}), 32'd0);
    end else if (valid_out) begin
      w   = mem[exp_pc[9:2]];
      nxt = ref_next(exp_pc, w, taken);
      chk("stream_pc", pc_out, exp_pc);
      chk("stream_instr", instr_out, w);
      chk1("stream_pred", branch_predicted_taken_out, taken);
      chk1("stream_no_exc", exception_out, 1'b0);
      exp_pc = nxt;
      emitted++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk1("rst_read", instr_read_out, 1'b0);
    chk1("rst_valid", valid_out, 1'b0);
    chk1("rst_exc", exception_out, 1'b0);
    chk1("rst_bpt", branch_predicted_taken_out, 1'b0);
    chk("rst_cause", 32'(exception_cause_out), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    stall_in = 1'b0;  flush_in = 1'b0;  redirect_in = 1'b0;  redirect_pc_in = 32'd0;
    instr_ready_in = 1'b0;  instr_fault_in = 1'b0;  instr_read_value_in = 32'd0;
    repeat (2) @(posedge clk);
    #1 chk1("rst_read_held", instr_read_out, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_pc = 32'd0;
    wait_left = 0;
    #1;
    chk1("rst_first_req", instr_read_out, 1'b1);
    chk("rst_first_addr", instr_address_out, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_in = 1'b1;  flush_in = 1'b1;  redirect_pc_in = target;
    cycle();
    redirect_in = 1'b0;  flush_in = 1'b0;
  endtask

  initial begin
    int r;
    reset_n = 1'b1;
    stall_in = 1'b0;  flush_in = 1'b0;  redirect_in = 1'b0;  redirect_pc_in = 32'd0;
    instr_ready_in = 1'b0;  instr_fault_in = 1'b0;  instr_read_value_in = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    @(negedge clk);

    // Sequential fetch with a zero-wait bus
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk("seq_addr", instr_address_out, 32'(4 * i));
      cycle();
      chk1("seq_valid", valid_out, 1'b1);
      chk("seq_pc_out", pc_out, 32'(4 * i));
    end

    // JAL predicted taken
    mem[0] = 32'h1000_00EF;
    do_reset();
    cycle();
    chk("jal_pc_out", pc_out, 32'h0);
    chk1("jal_bpt", branch_predicted_taken_out, 1'b1);
    chk("jal_next_addr", instr_address_out, 32'h100);
    cycle();
    chk("jal_target_pc", pc_out, 32'h100);
    chk1("jal_target_bpt", branch_predicted_taken_out, 1'b0);
    mem[0] = 32'h0000_0013;

    // Backward branch, then redirect to 0x14
    mem[4] = 32'hFE00_0CE3;
    redirect_to(32'h10);
    chk("br_req_addr", instr_address_out, 32'h10);
    cycle();
    chk("br_pc_out", pc_out, 32'h10);
    chk1("br_bpt", branch_predicted_taken_out, 1'b1);
    chk("br_next_addr", instr_address_out, 32'h8);
    redirect_to(32'h14);
    chk1("redir_bubble", valid_out, 1'b0);
    chk("redir_addr", instr_address_out, 32'h14);
    cycle();
    chk("redir_pc_out", pc_out, 32'h14);
    chk1("redir_valid", valid_out, 1'b1);
    mem[4] = 32'h0000_0013;

    // Stall while the response for 0x4 arrives
    do_reset();
    cycle();
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("hold_no_req", instr_read_out, 1'b0);
      chk("hold_pc_out", pc_out, 32'h0);
    end
    stall_in = 1'b0;
    cycle();
    chk("hold_release_pc", pc_out, 32'h4);
    chk1("hold_release_valid", valid_out, 1'b1);
    chk("hold_next_addr", instr_address_out, 32'h8);
    cycle();
    chk("hold_after_pc", pc_out, 32'h8);

    // Redirect during a 3-wait-state request
    redirect_to(32'h20);
    wait_left = 3;
    redirect_to(32'h40);
    for (int i = 0; i < 3; i++) begin
      chk("drain_addr", instr_address_out, 32'h20);
      chk1("drain_read", instr_read_out, 1'b1);
      cycle();
      chk1("drain_no_valid", valid_out, 1'b0);
    end
    chk("drain_new_addr", instr_address_out, 32'h40);
    cycle();
    chk("drain_pc_out", pc_out, 32'h40);
    chk1("drain_valid", valid_out, 1'b1);

    // Misaligned redirect target
    redirect_to(32'h102);
    chk1("mis_no_req", instr_read_out, 1'b0);
    cycle();
    chk1("mis_exc", exception_out, 1'b1);
    chk("mis_cause", 32'(exception_cause_out), 32'd0);
    chk("mis_pc_out", pc_out, 32'h102);
    chk("mis_instr_out", instr_out, 32'd0);
    chk1("mis_valid", valid_out, 1'b0);
    cycle();
    chk1("mis_halt_no_req", instr_read_out, 1'b0);
    chk1("mis_halt_bubble", exception_out, 1'b0);

    // Access fault at 0x8
    fault_on = 1'b1;  fault_addr = 32'h8;
    redirect_to(32'h8);
    cycle();
    chk1("flt_exc", exception_out, 1'b1);
    chk("flt_cause", 32'(exception_cause_out), 32'd1);
    chk1("flt_valid", valid_out, 1'b0);
    chk("flt_pc_out", pc_out, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk1("flt_no_req", instr_read_out, 1'b0);
    end
    fault_on = 1'b0;
    redirect_to(32'h0);
    cycle();
    chk1("flt_recover_valid", valid_out, 1'b1);
    chk("flt_recover_pc", pc_out, 32'h0);

    // Randomized program image, wait states, stalls and redirects
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3: mem[i] = {$urandom_range(0, 32'h01FF_FFFF), 7'h13};
        4:          mem[i] = $urandom;
        5:          mem[i] = enc_b(4 * int'($urandom_range(1, 16)));
        6:          mem[i] = enc_b(-4 * int'($urandom_range(1, 16)));
        7:          mem[i] = enc_j(4 * (int'($urandom_range(0, 128)) - 64));
        default:    mem[i] = 32'h0000_0013;
      endcase
    end
    wait_mode = -1;
    do_reset();
    emitted = 0;
    for (int c = 0; c < 3000; c++) begin
      stall_in       = ($urandom_range(0, 3) == 0);
      redirect_in    = ($urandom_range(0, 31) == 0);
      flush_in       = redirect_in;
      redirect_pc_in = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      cycle();
    end
    stall_in = 1'b0;  redirect_in = 1'b0;  flush_in = 1'b0;
    chk1("rand_emitted", emitted > 200, 1'b1);

    // Asynchronous reset while a request is outstanding
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    wait_mode = 0;
    do_reset();
    cycle();
    cycle();
    chk("pre_areset_pc", pc_out, 32'h4);
    wait_left = 5;
    cycle();
    chk1("pre_areset_req", instr_read_out, 1'b1);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv32_fetch.md
Name: rv32_fetch

Overview:
Instruction fetch stage of the rv32 pipeline. It produces the valid/exception/pc/instr/branch_predicted_taken stream that the decode stage consumes. It owns the PC register, drives a single-outstanding-request instruction bus, and makes static BTFN branch predictions. It redirects on mispredict, trap or mret reported by later stages.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
stall_in  in  1  from hazard; hold output registers
flush_in  in  1  from hazard; bubble the output registers
redirect_in  in  1  later stage (mispredict/trap/mret) requests PC change
redirect_pc_in  in  32  new PC when redirect_in=1
instr_address_out  out  32  bus address
instr_read_out  out  1  bus request
instr_read_value_in  in  32  bus read data
instr_ready_in  in  1  bus completes the current request this cycle
instr_fault_in  in  1  access fault; qualified by instr_ready_in
valid_out  out  1  instruction valid to decode
exception_out  out  1  fetch exception to decode
exception_cause_out  out  4  mcause code
branch_predicted_taken_out  out  1  prediction applied to pc_out
pc_out  out  32  PC of instr_out
instr_out  out  32  fetched instruction

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc = RESET_VECTOR; state = FETCH.
  - valid_out, exception_out, branch_predicted_taken_out, exception_cause_out, pc_out and instr_out all 0.
  - instr_read_out = 0 while reset is asserted.
- Bus protocol:
  - instr_address_out and instr_read_out must stay stable from assertion until a cycle with instr_ready_in=1.
  - At most one request is outstanding.
  - instr_read_out = 1 in FETCH and DRAIN when pc[1:0]==0.
- States:
  - FETCH: request at pc. On ready:
    - If stall_in=0 and no redirect: the result goes directly to the output registers.
    - If stall_in=1: the result goes into the skid buffer (instr, fault, pc, prediction) and the state moves to HOLD.
  - HOLD: no request. When stall_in=0, the output registers take the skid contents and the state returns to FETCH.
  - DRAIN: the outstanding request targets a discarded address. On ready, the data is dropped and the state moves to FETCH at pc, which already holds the redirect target.
- Redirect (highest priority):
  - redirect_in=1 loads pc = redirect_pc_in.
  - FETCH with no ready this cycle → DRAIN.
  - FETCH with ready this cycle, or HOLD → discard the data, → FETCH.
  - DRAIN → stays in DRAIN; pc is overwritten.
- Next pc on accepted fetch (no redirect):
  - JAL (opcode 1101111): pc + J-imm, predicted taken.
  - Branch (opcode 1100011) with imm[12]=1 (backward): pc + B-imm, predicted taken.
  - Otherwise: pc + 4, not taken.
  - On fault: pc + 4, not taken.
  - Arithmetic is 32-bit and wraps modulo 2^32.
- Exceptions:
  - Misaligned pc (pc[1:0]!=0) in FETCH: no bus request. The entry is emitted as exception_out=1, cause 4'd0, instr_out=0, valid_out=0.
  - After emitting it, the stage holds until redirect_in.
  - Fault on ready: emit exception_out=1, cause 4'd1, valid_out=0, then hold (no further fetch) until redirect_in.
- Output registers:
  - Update only when stall_in=0.
  - A cycle with nothing to emit loads a bubble (valid_out=0, exception_out=0, branch_predicted_taken_out=0).
  - flush_in=1 with stall_in=0 forces a bubble regardless of new data, and that data is discarded.
  - redirect_in and flush_in are asserted together by the hazard logic; redirect_in alone also forces a bubble.
- Throughput: one instruction per cycle with zero-wait bus. Latency is one cycle from ready to valid_out.

Test Plan:
1. Reset, RESET_VECTOR=0, zero-wait bus returns 0x00000013 for every address → addresses 0x0, 0x4, 0x8 on consecutive cycles; valid_out=1 with pc_out 0x0, 0x4, 0x8 one cycle later.
2. Word at 0x0 = 0x100000EF (jal x1,0x100) → next address 0x100; pc_out=0x0 with branch_predicted_taken_out=1.
3. Word at 0x10 = 0xFE000CE3 (beq x0,x0,-8) → next address 0x8, predicted taken. Then redirect_in=1 with redirect_pc_in=0x14 → next request 0x14, bubble output.
4. stall_in=1 for 3 cycles while ready arrives at 0x4 → outputs frozen, HOLD, no new request. On stall release, pc_out=0x4 with valid_out=1, then the request at 0x8; no loss, no duplicate.
5. Bus 3-wait-state request at 0x20, redirect to 0x40 in its first cycle → address stays 0x20 until ready, data dropped, then request 0x40; valid_out is never 1 for 0x20.
6. redirect_pc_in=0x102 → exception_out=1, cause 0, pc_out=0x102, instr_read_out=0. Separately, instr_fault_in at 0x8 → exception_out=1, cause 1, no further requests until redirect. Async reset_n low mid-request → outputs immediately 0.
